// File: rtl/display_mode_scheduler_if.sv
// Frame channel between the display mode scheduler, the time/date frame
// requesters and the LED controller. The scheduler is the master: it samples
// the two source frames and drives dat/dat_vld toward the LED controller,
// which answers with dat_rdy.
interface display_mode_scheduler_if #(
  parameter int DAT_WIDTH = 64
);
  logic [DAT_WIDTH-1:0] time_dat;
  logic [DAT_WIDTH-1:0] date_dat;
  logic [DAT_WIDTH-1:0] dat;
  logic                 dat_vld;
  logic                 dat_rdy;

  modport master (
    input  time_dat,
    input  date_dat,
    input  dat_rdy,
    output dat,
    output dat_vld
  );

  modport slave (
    output time_dat,
    output date_dat,
    output dat_rdy,
    input  dat,
    input  dat_vld
  );
endinterface

// File: rtl/display_mode_scheduler.sv
// Display mode scheduler: picks between the time and date frames for an
// 8-digit LED display. A debounced button peeks at the date for PEEK_SEC
// seconds, a switch locks the date on screen, and a fresh frame is offered
// to the LED controller on every 1 s tick and on every mode change.
module display_mode_scheduler #(
  parameter int CLK_HZ    = 125000000,
  parameter int DEB_CYC   = 1250000,
  parameter int PEEK_SEC  = 5,
  parameter int DAT_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            btn,
  input  logic                            sw0,
  display_mode_scheduler_if.master        bus,
  output logic                            mode,
  output logic                            tick
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int PW = $clog2(PEEK_SEC + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [PW-1:0] PEEK_LOAD = PW'(PEEK_SEC);
  localparam logic [PW-1:0] PEEK_ONE  = PW'(1);

  localparam logic [1:0] S_TIME = 2'd0;
  localparam logic [1:0] S_PEEK = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  logic                 btn_m, btn_s;
  logic                 sw0_m, sw0_s;
  logic [DW-1:0]        deb_cnt;
  logic                 btn_db, btn_db_q;
  logic                 press;
  logic [TW-1:0]        tick_cnt;
  logic [1:0]           state, state_nx;
  logic [PW-1:0]        peek_cnt, peek_nx;
  logic                 mode_nx;
  logic                 req;
  logic                 pend;
  logic                 issue;
  logic [DAT_WIDTH-1:0] dat_q;
  logic                 vld_q;

  // Two-flop synchronizers for the asynchronous button and switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw0_m <= 1'b0;
      sw0_s <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage captures the previous stage's pre-edge value.
      btn_m <= btn;
      btn_s <= btn_m;
      sw0_m <= sw0;
      sw0_s <= sw0_m;
    end
  end

  // Debounce: the synchronized button must differ from btn_db for DEB_CYC
  // consecutive cycles before btn_db follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt  <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_db  <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  // Free-running seconds divider; tick marks its last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Next-state logic: the lock switch overrides everything, a press beats
  // a coincident tick, and the peek countdown only runs on ticks.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nx = state;
    peek_nx  = peek_cnt;
    if (sw0_s) begin
      state_nx = S_LOCK;
    end else begin
      case (state)
        S_TIME: begin
          if (press) begin
            state_nx = S_PEEK;
            peek_nx  = PEEK_LOAD;
          end
        end
        S_PEEK: begin
          if (press) begin
            state_nx = S_TIME;
          end else if (tick) begin
            peek_nx = peek_cnt - PEEK_ONE;
            if (peek_cnt == PEEK_ONE) begin
              state_nx = S_TIME;
            end
          end
        end
        S_LOCK:  state_nx = S_TIME;
        default: state_nx = S_TIME;
      endcase
    end
  end

  assign mode    = (state != S_TIME);
  assign mode_nx = (state_nx != S_TIME);

  // A request is a tick or a mode change; it is served at once when the
  // channel is idle, otherwise it is remembered in pend and coalesced.
  assign req   = tick | (mode_nx ^ mode);
  assign issue = ~vld_q & (pend | req);

  // Mode FSM, peek countdown and pending-request flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_TIME;
      peek_cnt <= '0;
      pend     <= 1'b1;
    end else begin
      state    <= state_nx;
      peek_cnt <= peek_nx;
      pend     <= (pend | req) & ~issue;
    end
  end

  // Output channel: latch the frame of the upcoming mode on issue, hold it
  // until the LED controller takes it, then stay idle for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else if (issue) begin
      dat_q <= mode_nx ? bus.date_dat : bus.time_dat;
      vld_q <= 1'b1;
    end else if (vld_q && bus.dat_rdy) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.dat     = dat_q;
  assign bus.dat_vld = vld_q;

endmodule

// File: doc/display_mode_scheduler.md
DISPLAY_MODE_SCHEDULER -- requirements
Module: display_mode_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CLK_HZ, 125000000, clk cycles per 1 s tick
- DEB_CYC, 1250000, debounce stability window in cycles (10 ms)
- PEEK_SEC, 5, date-peek auto-return time in ticks
- DAT_WIDTH, 64, display frame width (8 digits x 8 segments)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock; all logic on posedge
- rst, in, 1, synchronous, active-high reset
- btn, in, 1, raw asynchronous mode button
- sw0, in, 1, raw asynchronous date-lock switch
- time_dat, in, DAT_WIDTH, hh-mm-ss segment frame from time requester
- date_dat, in, DAT_WIDTH, ddmmyyyy segment frame from date requester
- dat_rdy, in, 1, LED controller accepts frame when high with dat_vld
- dat, out, DAT_WIDTH, frame to LED controller
- dat_vld, out, 1, frame valid
- mode, out, 1, 0 = time shown, 1 = date shown
- tick, out, 1, one-cycle 1 Hz strobe

Function
REQ-003 btn and sw0 SHALL each pass a 2-FF synchronizer (btn_s, sw0_s); sw0 is not debounced.
REQ-004 Debouncer: counter SHALL clear whenever btn_s equals btn_db; otherwise increment; at DEB_CYC-1 it SHALL load btn_db <= btn_s and clear.
REQ-005 press SHALL be a one-cycle pulse on the 0->1 transition of btn_db.
REQ-006 Tick counter SHALL count 0..CLK_HZ-1 and wrap; tick SHALL be high exactly in the cycle the count equals CLK_HZ-1.
REQ-007 The FSM SHALL have three states: S_TIME (mode=0), S_PEEK (mode=1), S_LOCK (mode=1).
REQ-008 From any state, sw0_s=1 SHALL go to S_LOCK; sw0 has priority over press and tick.
REQ-009 S_LOCK with sw0_s=0 SHALL go to S_TIME; press is ignored in S_LOCK.
REQ-010 S_TIME with press SHALL go to S_PEEK and load peek_cnt <= PEEK_SEC.
REQ-011 S_PEEK with press SHALL go to S_TIME; press has priority over a simultaneous tick.
REQ-012 S_PEEK with tick and no press SHALL decrement peek_cnt; when peek_cnt=1 at that tick, the FSM SHALL go to S_TIME.
REQ-013 A frame request flag (pend) SHALL be set by tick, by any change of mode, and by reset release.
REQ-014 Issue rule: when pend=1 and dat_vld=0, the next cycle SHALL latch dat from the source selected by the next-state mode, set dat_vld=1 and clear pend.
REQ-015 Handshake: dat and dat_vld SHALL stay stable while dat_vld=1 and dat_rdy=0; transfer occurs on dat_vld&dat_rdy; dat_vld SHALL be 0 the following cycle.
REQ-016 A request arriving while a frame is outstanding SHALL keep pend=1 and issue after acceptance; requests coalesce and none is lost or duplicated.
REQ-017 Latency: tick or mode change in cycle N with the channel idle SHALL give dat_vld=1 in cycle N+1.
REQ-018 Source inputs are sampled only at issue; changes while dat_vld=1 do not affect dat.

Reset
REQ-019 On rst=1 at a clk edge: state=S_TIME, mode=0, dat=0, dat_vld=0, tick=0, counters=0, btn_db=0, synchronizers=0, peek_cnt=0, pend=1.
REQ-020 Reset mid-transfer SHALL drop dat_vld the next cycle without handshake; the first frame (time_dat) SHALL issue in the first cycle after rst falls.

Verification (CLK_HZ=10, DEB_CYC=3, PEEK_SEC=2, dat_rdy=1 unless stated)
REQ-021 Reset release, time_dat=64'h1 -> dat_vld=1, dat=64'h1, mode=0 one cycle later; tick every 10 cycles thereafter, with a time frame after each.
REQ-022 btn glitch of 2 cycles -> no mode change; btn held 6 cycles -> mode=1, date_dat frame issued; after 2 ticks with no press -> mode=0, time_dat frame issued.
REQ-023 In S_PEEK, press coincident with tick -> S_TIME, exactly one time_dat frame issued, peek_cnt not decremented.
REQ-024 sw0=1 during S_PEEK with press pending -> S_LOCK, mode=1, no auto-return over 5 ticks; sw0=0 -> mode=0 within 3 cycles.
REQ-025 dat_rdy=0 for 25 cycles spanning 2 ticks and a mode change -> dat and dat_vld held stable; after dat_rdy=1, exactly one further frame issues, from the current mode source.
REQ-026 rst asserted while dat_vld=1 and dat_rdy=0 -> dat_vld=0 and dat=0 next cycle; after release, a time_dat frame issues.
